// File: rtl/vga_timing_if.sv
// Video timing bundle from the raster generator to the pixel/colour stage.
interface vga_timing_if #(
  parameter int unsigned POS_W = 11
);
  logic             Hsync;
  logic             Vsync;
  logic [POS_W-1:0] Hpos;
  logic [POS_W-1:0] Vpos;
  logic             active;
  logic             vblank;
  logic             line_start;
  logic             frame_start;

  modport master (
    output Hsync, Vsync, Hpos, Vpos, active, vblank, line_start, frame_start
  );

  modport slave (
    input Hsync, Vsync, Hpos, Vpos, active, vblank, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: position counters plus registered sync and
// blanking strobes, all decoded from the next counter values so they align with Hpos/Vpos.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          H_SYNC_POL = 1'b0,
  parameter bit          V_SYNC_POL = 1'b0,
  parameter int unsigned POS_W      = 11
) (
  input logic          clk,
  input logic          reset,
  input logic          enable,
  vga_timing_if.master vid
);

  localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [POS_W-1:0] HLast      = POS_W'(HTotal - 1);
  localparam logic [POS_W-1:0] VLast      = POS_W'(VTotal - 1);
  localparam logic [POS_W-1:0] HActive    = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] VActive    = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] HSyncStart = POS_W'(H_ACTIVE + H_FP);
  localparam logic [POS_W-1:0] HSyncEnd   = POS_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [POS_W-1:0] VSyncStart = POS_W'(V_ACTIVE + V_FP);
  localparam logic [POS_W-1:0] VSyncEnd   = POS_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [POS_W-1:0] hpos_q, hpos_d;
  logic [POS_W-1:0] vpos_q, vpos_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic active_q, active_d;
  logic vblank_q, vblank_d;
  logic line_start_q, line_start_d;
  logic frame_start_q, frame_start_d;

  always_comb begin
    hpos_d = hpos_q + POS_W'(1);
    vpos_d = vpos_q;
    if (hpos_q == HLast) begin
      hpos_d = '0;
      vpos_d = (vpos_q == VLast) ? '0 : vpos_q + POS_W'(1);
    end

    // Strobes are decoded from the advanced counters so they land on the same edge.
    hsync_d       = ((hpos_d >= HSyncStart) && (hpos_d < HSyncEnd)) ? H_SYNC_POL : ~H_SYNC_POL;
    vsync_d       = ((vpos_d >= VSyncStart) && (vpos_d < VSyncEnd)) ? V_SYNC_POL : ~V_SYNC_POL;
    active_d      = (hpos_d < HActive) && (vpos_d < VActive);
    vblank_d      = (vpos_d >= VActive);
    line_start_d  = (hpos_d == '0);
    frame_start_d = (hpos_d == '0) && (vpos_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Last back-porch pixel of the last line: the first tick lands on (0,0).
      hpos_q        <= HLast;
      vpos_q        <= VLast;
      hsync_q       <= ~H_SYNC_POL;
      vsync_q       <= ~V_SYNC_POL;
      active_q      <= 1'b0;
      vblank_q      <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (enable) begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      vblank_q      <= vblank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign vid.Hsync       = hsync_q;
  assign vid.Vsync       = vsync_q;
  assign vid.Hpos        = hpos_q;
  assign vid.Vpos        = vpos_q;
  assign vid.active      = active_q;
  assign vid.vblank      = vblank_q;
  assign vid.line_start  = line_start_q;
  assign vid.frame_start = frame_start_q;

endmodule
